// File: rtl/mod_demodulator_pkg.sv
// Shared types and constants for the modulation demodulator.
package mod_demodulator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_MEASURE,
    S_LOCKED
  } state_t;

  localparam int   MOD_PRESCALE   = 4;
  localparam logic MOD_IDLE_LEVEL = 1'b1;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mod_demodulator_if.sv
// Demodulator signal bundle: slave is the demodulator, master is whoever drives mod_in and reads status.
interface mod_demodulator_if #(
  parameter int CNT_W = 16
);
  logic             mod_in;
  logic [CNT_W-1:0] meas_cycles;
  logic [15:0]      meas_half_period;
  logic             meas_valid;
  logic             mod_locked;
  logic             mod_idle;
  logic             duty_err;

  modport master (
    output mod_in,
    input  meas_cycles, meas_half_period, meas_valid, mod_locked, mod_idle, duty_err
  );

  modport slave (
    input  mod_in,
    output meas_cycles, meas_half_period, meas_valid, mod_locked, mod_idle, duty_err
  );
endinterface

// File: rtl/mod_demodulator_sync_edge.sv
// Input synchronizer (preset to idle level) with registered edge strobe and current synchronized level.
module mod_demodulator_sync_edge
  import mod_demodulator_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic edge_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   edge_q;

  // lvl_q takes the new level in the same cycle edge_q fires, so level_o is the post-edge level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{MOD_IDLE_LEVEL}};
      lvl_q  <= MOD_IDLE_LEVEL;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      lvl_q  <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] ^ lvl_q;
    end
  end

  assign edge_o  = edge_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/mod_demodulator.sv
// Square-wave envelope demodulator: measures mod_in half-period, reports it with lock/idle status.
// Defining MOD_DUTY_CHECK_EN adds separate high/low interval tracking driving duty_err.
module mod_demodulator
  import mod_demodulator_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int PRESCALE    = MOD_PRESCALE,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = 256
) (
  input logic              clk,
  input logic              rst,
  mod_demodulator_if.slave bus
);

  localparam int               SH        = $clog2(PRESCALE);
  localparam int               MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_COUNT);

  logic edge_det;
  logic level;

  mod_demodulator_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .din_i  (bus.mod_in),
    .edge_o (edge_det),
    .level_o(level)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lprev_q, lprev_d;
  logic [CNT_W-1:0] meas_cycles_q, meas_cycles_d;
  logic [15:0]      hp_q, hp_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             idle_q, idle_d;
  logic [MW-1:0]    match_q, match_d;
  logic [MW-1:0]    match_inc;
  logic             duty_clr;

  // Rounded division by PRESCALE, widened so the rounding add cannot wrap
  logic [CNT_W:0] rnd_sum;
  logic [CNT_W:0] rnd_quo;
  logic [32:0]    quo_w;
  logic [15:0]    hp_calc;
  logic           in_tol;
  logic           timeout;

  assign rnd_sum   = {1'b0, cnt_q} + (CNT_W+1)'(PRESCALE / 2);
  assign rnd_quo   = rnd_sum >> SH;
  assign quo_w     = 33'(rnd_quo);
  assign hp_calc   = (quo_w > 33'h0FFFF) ? 16'hFFFF : quo_w[15:0];
  assign in_tol    = abs_diff(32'(cnt_q), 32'(lprev_q)) <= 32'(TOL);
  assign timeout   = (cnt_q == TIMEOUT_C) && (state_q != S_IDLE);
  assign match_inc = match_q + MW'(1);

  // Counter holds cycles since the last edge, so at the next edge it equals the interval length
  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    lprev_d       = lprev_q;
    meas_cycles_d = meas_cycles_q;
    hp_d          = hp_q;
    valid_d       = 1'b0;
    locked_d      = locked_q;
    idle_d        = idle_q;
    match_d       = match_q;
    duty_clr      = 1'b0;
    if (edge_det && timeout) begin
      // An edge landing on the timeout cycle restarts acquisition as if from idle
      state_d  = S_SYNC;
      locked_d = 1'b0;
      match_d  = '0;
      duty_clr = 1'b1;
    end else if (state_q == S_IDLE) begin
      if (edge_det) begin
        state_d = S_SYNC;
        idle_d  = 1'b0;
      end
    end else if (edge_det) begin
      valid_d       = 1'b1;
      meas_cycles_d = cnt_q;
      hp_d          = hp_calc;
      lprev_d       = cnt_q;
      case (state_q)
        S_SYNC: begin
          state_d = S_MEASURE;
          match_d = MW'(1);
        end
        S_MEASURE: begin
          if (in_tol) begin
            match_d = match_inc;
            if (match_inc == LOCK_C) begin
              state_d  = S_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = MW'(1);
          end
        end
        S_LOCKED: begin
          if (!in_tol) begin
            state_d  = S_MEASURE;
            match_d  = MW'(1);
            locked_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d  = S_IDLE;
      idle_d   = 1'b1;
      locked_d = 1'b0;
      match_d  = '0;
      duty_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      lprev_q       <= '0;
      meas_cycles_q <= '0;
      hp_q          <= '0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      idle_q        <= 1'b1;
      match_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lprev_q       <= lprev_d;
      meas_cycles_q <= meas_cycles_d;
      hp_q          <= hp_d;
      valid_q       <= valid_d;
      locked_q      <= locked_d;
      idle_q        <= idle_d;
      match_q       <= match_d;
    end
  end

  assign bus.meas_cycles      = meas_cycles_q;
  assign bus.meas_half_period = hp_q;
  assign bus.meas_valid       = valid_q;
  assign bus.mod_locked       = locked_q;
  assign bus.mod_idle         = idle_q;

`ifdef MOD_DUTY_CHECK_EN
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             have_h_q, have_h_d;
  logic             have_l_q, have_l_d;
  logic             duty_q, duty_d;

  // level is the post-edge level, so the interval just closed had the opposite level
  always_comb begin
    high_d   = high_q;
    low_d    = low_q;
    have_h_d = have_h_q;
    have_l_d = have_l_q;
    duty_d   = duty_q;
    if (duty_clr) begin
      have_h_d = 1'b0;
      have_l_d = 1'b0;
      duty_d   = 1'b0;
    end else if (valid_d) begin
      if (!level) begin
        high_d   = cnt_q;
        have_h_d = 1'b1;
      end else begin
        low_d    = cnt_q;
        have_l_d = 1'b1;
      end
      if (have_h_d && have_l_d) begin
        duty_d = abs_diff(32'(high_d), 32'(low_d)) > 32'(TOL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      high_q   <= '0;
      low_q    <= '0;
      have_h_q <= 1'b0;
      have_l_q <= 1'b0;
      duty_q   <= 1'b0;
    end else begin
      high_q   <= high_d;
      low_q    <= low_d;
      have_h_q <= have_h_d;
      have_l_q <= have_l_d;
      duty_q   <= duty_d;
    end
  end

  assign bus.duty_err = duty_q;
`else
  logic unused_level;
  logic unused_duty_clr;
  assign unused_level    = level;
  assign unused_duty_clr = duty_clr;
  assign bus.duty_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mod_demodulator.sv
// Scoreboarded bench for mod_demodulator: interval-level reference model, decoupled output monitor.
module tb_mod_demodulator;

  localparam int CNT_W       = 16;
  localparam int PRESCALE    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_COUNT  = 4;
  localparam int TOL         = 1;
  localparam int TIMEOUT     = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_demodulator_if #(.CNT_W(CNT_W)) bus ();

  mod_demodulator #(
    .CNT_W      (CNT_W),
    .PRESCALE   (PRESCALE),
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_COUNT (LOCK_COUNT),
    .TOL        (TOL),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int l;
    int hp;
    bit locked;
    bit duty;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_tgl = 0;

  // Reference model state: interval history only
  bit m_active;
  int m_prev;
  int m_run;
  bit m_locked;
  bit m_derr;
  int m_high, m_low;
  bit m_have_h, m_have_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int exp_hp(input int l);
    int q;
    q = (l + PRESCALE / 2) / PRESCALE;
    return (q > 65535) ? 65535 : q;
  endfunction

  task automatic model_restart(input bit active);
    m_active = active;
    m_run    = 0;
    m_prev   = 0;
    m_locked = 0;
    m_derr   = 0;
    m_have_h = 0;
    m_have_l = 0;
  endtask

  // One mod_in transition closing an interval of length l whose level was old_lvl
  task automatic model_edge(input int l, input bit old_lvl);
    bit   match;
    exp_t e;
    if (!m_active || l >= TIMEOUT) begin
      model_restart(1'b1);
      return;
    end
    match    = (m_run > 0) && (abs_i(l - m_prev) <= TOL);
    m_run    = match ? m_run + 1 : 1;
    m_locked = m_locked ? match : (m_run >= LOCK_COUNT);
    m_prev   = l;
`ifdef MOD_DUTY_CHECK_EN
    if (old_lvl) begin
      m_high = l; m_have_h = 1;
    end else begin
      m_low = l; m_have_l = 1;
    end
    if (m_have_h && m_have_l) m_derr = abs_i(m_high - m_low) > TOL;
`else
    if (old_lvl) m_high = l; else m_low = l;
`endif
    e.l      = l;
    e.hp     = exp_hp(l);
    e.locked = m_locked;
    e.duty   = m_derr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Toggle mod_in once n cycles have elapsed since the previous toggle
  task automatic toggle(input int n);
    bit old_lvl;
    int l;
    while (cyc - last_tgl < n) step();
    old_lvl    = bus.mod_in;
    bus.mod_in = ~bus.mod_in;
    l          = cyc - last_tgl;
    last_tgl   = cyc;
    model_edge(l, old_lvl);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_meas_valid", bus.meas_valid, 0);
    check("rst_meas_cycles", bus.meas_cycles, 0);
    check("rst_half_period", bus.meas_half_period, 0);
    check("rst_locked", bus.mod_locked, 0);
    check("rst_idle", bus.mod_idle, 1);
    check("rst_duty_err", bus.duty_err, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got strobe with meas_cycles=%0d, expected no strobe (t=%0t)",
                 bus.meas_cycles, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("meas_cycles", bus.meas_cycles, mon_e.l);
        check("meas_half_period", bus.meas_half_period, mon_e.hp);
        check("mod_locked", bus.mod_locked, mon_e.locked);
        check("mod_idle_on_valid", bus.mod_idle, 0);
        check("duty_err", bus.duty_err, mon_e.duty);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int p;
    int n;
    int r;
    rst        = 1'b1;
    bus.mod_in = 1'b1;
    model_restart(1'b0);
    repeat (3) step();
    check_reset_values();
    rst      = 1'b0;
    last_tgl = cyc;

    // Static input: stays idle, no strobes
    repeat (500) step();
    check("static_idle", bus.mod_idle, 1);
    check("static_unlocked", bus.mod_locked, 0);
    check("static_no_valid", exp_q.size(), 0);

    // 12-cycle halves, lock on fifth edge
    repeat (8) toggle(12);
    drain("drain_12");
    check("locked_12", bus.mod_locked, 1);

    // Period change while locked, then relock
    repeat (8) toggle(24);
    drain("drain_24");
    check("locked_24", bus.mod_locked, 1);

    // Tolerance boundary
    repeat (6) toggle(12);
    toggle(13);
    toggle(12);
    toggle(11);
    toggle(12);
    drain("drain_tol");
    check("locked_tol", bus.mod_locked, 1);
    toggle(14);
    drain("drain_drop");
    check("unlocked_14", bus.mod_locked, 0);

    // Timeout to idle, then resume
    repeat (300) step();
    check("timeout_idle", bus.mod_idle, 1);
    check("timeout_unlocked", bus.mod_locked, 0);
    check("timeout_duty", bus.duty_err, 0);
    repeat (8) toggle(12);
    drain("drain_resume");
    check("locked_resume", bus.mod_locked, 1);

    // Randomized periods, jitter and gaps straddling the timeout
    p = 12;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) p = int'($urandom_range(6, 40));
      if (r == 1) n = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
      else        n = p + int'($urandom_range(0, 4)) - 2;
      if (n < 4) n = 4;
      toggle(n);
    end
    drain("drain_random");

    // Reset while locked
    repeat (8) toggle(12);
    drain("drain_prerst");
    check("locked_prerst", bus.mod_locked, 1);
    rst = 1'b1;
    step();
    check_reset_values();
    bus.mod_in = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    model_restart(1'b0);
    last_tgl = cyc;
    repeat (8) toggle(16);
    drain("drain_postrst");
    check("locked_postrst", bus.mod_locked, 1);

`ifdef MOD_DUTY_CHECK_EN
    // Asymmetric duty: high 12, low 16
    for (int i = 0; i < 8; i++) toggle(bus.mod_in ? 12 : 16);
    drain("drain_duty");
    check("duty_err_set", bus.duty_err, 1);
`endif

    repeat (10) step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
